// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared EX->MEM pipeline types: control bundle layout, widths and skid-register state encoding.
package pipe_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regWrite;
    logic       branch;
    logic       less;
    logic       zero;
    logic [3:0] funct;
    logic       spare;
  } ex_mem_ctrl_t;

  localparam int unsigned CTRL_W = $bits(ex_mem_ctrl_t);

  // Encoding mirrors {skid valid, main valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  function automatic logic [1:0] stateCount(input state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ex_mem_skid_reg_if.sv
// Valid/ready channel carrying one EX->MEM entry (control bundle, destination register, payload).
interface ex_mem_skid_reg_if #(
  parameter int unsigned DATA_W = pipe_pkg::XLEN,
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
  parameter int unsigned RD_W   = pipe_pkg::REG_ADDR_W
);

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [RD_W-1:0]   rd;
  logic [DATA_W-1:0] data;

  modport master (output valid, ctrl, rd, data, input ready);
  modport slave  (input valid, ctrl, rd, data, output ready);

endinterface

// File: rtl/ex_mem_skid_reg_slot.sv
// One storage slot of the skid register: valid bit plus ctrl/rd/data, with load, drop and clear.
module pipe_slot #(
  parameter int unsigned DATA_W              = 64,
  parameter int unsigned CTRL_W              = 12,
  parameter int unsigned RD_W                = 5,
  parameter int unsigned ZERO_DATA_ON_BUBBLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [CTRL_W-1:0] ctrlIn,
  input  logic [RD_W-1:0]   rdIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [RD_W-1:0]   rd,
  output logic [DATA_W-1:0] data
);

  // Control is zeroed whenever the slot goes empty so a bubble never carries a write enable.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      rd    <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ctrlIn;
      rd    <= rdIn;
      data  <= dataIn;
    end else if (drop) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (ZERO_DATA_ON_BUBBLE != 0) begin
        rd   <= '0;
        data <= '0;
      end
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// Elastic EX->MEM stage register: two-entry skid buffer with registered in_ready and single-cycle flush.
module ex_mem_skid_reg #(
  parameter int unsigned DATA_W              = pipe_pkg::XLEN,
  parameter int unsigned CTRL_W              = pipe_pkg::CTRL_W,
  parameter int unsigned RD_W                = pipe_pkg::REG_ADDR_W,
  parameter int unsigned ZERO_DATA_ON_BUBBLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  ex_mem_skid_reg_if.slave         upstream,
  ex_mem_skid_reg_if.master        downstream,
  output logic [1:0]               count
);
  import pipe_pkg::*;

  state_e            state, stateNext;
  logic              inReady;
  logic              accept, pop;
  logic              mainLoad, mainDrop, skidLoad, skidDrop;
  logic              mainValid, skidValid;
  logic [CTRL_W-1:0] skidCtrl, mainCtrlSrc;
  logic [RD_W-1:0]   skidRd, mainRdSrc;
  logic [DATA_W-1:0] skidData, mainDataSrc;

  assign accept = upstream.valid & inReady;
  assign pop    = mainValid & downstream.ready;

  // Main refills from skid when it holds the older entry, otherwise straight from the input.
  assign mainCtrlSrc = skidValid ? skidCtrl : upstream.ctrl;
  assign mainRdSrc   = skidValid ? skidRd   : upstream.rd;
  assign mainDataSrc = skidValid ? skidData : upstream.data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_EMPTY;
      inReady <= 1'b1;
      count   <= 2'd0;
    end else begin
      state   <= stateNext;
      inReady <= (stateNext != ST_FULL);
      count   <= stateCount(stateNext);
    end
  end

  always_comb begin
    stateNext = state;
    mainLoad  = 1'b0;
    mainDrop  = 1'b0;
    skidLoad  = 1'b0;
    skidDrop  = 1'b0;
    if (flush) begin
      stateNext = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            mainLoad  = 1'b1;
            stateNext = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            mainLoad = 1'b1;
          end else if (accept) begin
            skidLoad  = 1'b1;
            stateNext = ST_FULL;
          end else if (pop) begin
            mainDrop  = 1'b1;
            stateNext = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            mainLoad  = 1'b1;
            skidDrop  = 1'b1;
            stateNext = ST_ONE;
          end
        end
        default: stateNext = ST_EMPTY;
      endcase
    end
  end

  pipe_slot #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W), .ZERO_DATA_ON_BUBBLE(ZERO_DATA_ON_BUBBLE)
  ) mainSlot (
    .clk(clk), .reset(reset), .clear(flush), .load(mainLoad), .drop(mainDrop),
    .ctrlIn(mainCtrlSrc), .rdIn(mainRdSrc), .dataIn(mainDataSrc),
    .valid(mainValid), .ctrl(downstream.ctrl), .rd(downstream.rd), .data(downstream.data)
  );

  pipe_slot #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W), .ZERO_DATA_ON_BUBBLE(ZERO_DATA_ON_BUBBLE)
  ) skidSlot (
    .clk(clk), .reset(reset), .clear(flush), .load(skidLoad), .drop(skidDrop),
    .ctrlIn(upstream.ctrl), .rdIn(upstream.rd), .dataIn(upstream.data),
    .valid(skidValid), .ctrl(skidCtrl), .rd(skidRd), .data(skidData)
  );

  assign upstream.ready   = inReady;
  assign downstream.valid = mainValid;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed and randomised checks of ex_mem_skid_reg against a queue-based reference model.
module tb_ex_mem_skid_reg;

  logic clk = 1'b0;
  logic reset, flush, resetB, flushB;
  logic [1:0] countA, countB;

  always #5 clk = ~clk;

  ex_mem_skid_reg_if #(.DATA_W(64), .CTRL_W(12), .RD_W(5)) upA ();
  ex_mem_skid_reg_if #(.DATA_W(64), .CTRL_W(12), .RD_W(5)) dnA ();
  ex_mem_skid_reg_if #(.DATA_W(32), .CTRL_W(4),  .RD_W(5)) upB ();
  ex_mem_skid_reg_if #(.DATA_W(32), .CTRL_W(4),  .RD_W(5)) dnB ();

  ex_mem_skid_reg #(.DATA_W(64), .CTRL_W(12), .RD_W(5), .ZERO_DATA_ON_BUBBLE(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .upstream(upA), .downstream(dnA), .count(countA)
  );

  ex_mem_skid_reg #(.DATA_W(32), .CTRL_W(4), .RD_W(5), .ZERO_DATA_ON_BUBBLE(1)) dutB (
    .clk(clk), .reset(resetB), .flush(flushB), .upstream(upB), .downstream(dnB), .count(countB)
  );

  typedef struct packed { logic [11:0] ctrl; logic [4:0] rd; logic [63:0] data; } entA_t;
  typedef struct packed { logic [3:0]  ctrl; logic [4:0] rd; logic [31:0] data; } entB_t;

  entA_t qA[$];
  entB_t qB[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sendA(input logic v, input logic [63:0] d, input logic [11:0] c, input logic [4:0] r);
    upA.valid = v;
    upA.data  = d;
    upA.ctrl  = c;
    upA.rd    = r;
  endtask

  // One clock of DUT A: predict accept/pop from the model, advance the scoreboard, compare outputs.
  task automatic cycA(input string ph);
    logic  acc, pp;
    entA_t e;
    int    n;
    n   = qA.size();
    acc = upA.valid && (n < 2);
    pp  = (n > 0) && dnA.ready;
    e   = {upA.ctrl, upA.rd, upA.data};
    @(posedge clk);
    #1;
    if (reset || flush) begin
      qA.delete();
    end else begin
      if (pp)  void'(qA.pop_front());
      if (acc) qA.push_back(e);
    end
    n = qA.size();
    chk({ph, " count"},     64'(countA),    64'(n));
    chk({ph, " in_ready"},  64'(upA.ready), 64'(n != 2));
    chk({ph, " out_valid"}, 64'(dnA.valid), 64'(n != 0));
    if (n != 0) begin
      chk({ph, " out_ctrl"}, 64'(dnA.ctrl), 64'(qA[0].ctrl));
      chk({ph, " out_rd"},   64'(dnA.rd),   64'(qA[0].rd));
      chk({ph, " out_data"}, dnA.data,      qA[0].data);
    end else begin
      chk({ph, " bubble ctrl"}, 64'(dnA.ctrl), 64'd0);
      chk({ph, " bubble rd"},   64'(dnA.rd),   64'd0);
      chk({ph, " bubble data"}, dnA.data,      64'd0);
    end
  endtask

  task automatic cycB(output logic acc, output logic pp);
    entB_t e;
    int    n;
    n   = qB.size();
    acc = upB.valid && (n < 2);
    pp  = (n > 0) && dnB.ready;
    e   = {upB.ctrl, upB.rd, upB.data};
    @(posedge clk);
    #1;
    if (resetB) begin
      qB.delete();
      acc = 1'b0;
      pp  = 1'b0;
    end else begin
      if (pp)  void'(qB.pop_front());
      if (acc) qB.push_back(e);
    end
    n = qB.size();
    chk("sweep count",     64'(countB),    64'(n));
    chk("sweep in_ready",  64'(upB.ready), 64'(n != 2));
    chk("sweep out_valid", 64'(dnB.valid), 64'(n != 0));
    if (n != 0) begin
      chk("sweep out_ctrl", 64'(dnB.ctrl), 64'(qB[0].ctrl));
      chk("sweep out_rd",   64'(dnB.rd),   64'(qB[0].rd));
      chk("sweep out_data", 64'(dnB.data), 64'(qB[0].data));
    end else begin
      chk("sweep bubble ctrl", 64'(dnB.ctrl), 64'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic acc, pp;
    int   sent, recv;
    reset = 1'b1; flush = 1'b0; resetB = 1'b1; flushB = 1'b0;
    sendA(1'b0, 64'd0, 12'd0, 5'd0);
    dnA.ready = 1'b1;
    upB.valid = 1'b0; upB.data = '0; upB.ctrl = '0; upB.rd = '0; dnB.ready = 1'b0;

    // Reset then stream four entries at full throughput.
    cycA("reset0");
    cycA("reset1");
    chk("reset in_ready", 64'(upA.ready), 64'd1);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sendA(1'b1, 64'(i), 12'(i), 5'(i));
      cycA("stream");
      chk("stream latency", dnA.data, 64'(i));
    end
    sendA(1'b0, 64'd0, 12'd0, 5'd0);
    cycA("stream drain");

    // Backpressure: A on output, B in skid, C held upstream.
    dnA.ready = 1'b0;
    sendA(1'b1, 64'hA, 12'h0A1, 5'd10);
    cycA("bp A");
    sendA(1'b1, 64'hB, 12'h0B1, 5'd11);
    cycA("bp B");
    chk("bp full count", 64'(countA), 64'd2);
    sendA(1'b1, 64'hC, 12'h0C1, 5'd12);
    cycA("bp C held");
    chk("bp head", dnA.data, 64'hA);
    dnA.ready = 1'b1;
    cycA("bp pop A");
    chk("bp second", dnA.data, 64'hB);
    cycA("bp pop B");
    chk("bp third", dnA.data, 64'hC);
    sendA(1'b0, 64'd0, 12'd0, 5'd0);
    cycA("bp pop C");

    // Flush in FULL drops both held entries and the concurrent input.
    dnA.ready = 1'b0;
    sendA(1'b1, 64'hA, 12'h3A, 5'd1);
    cycA("fl A");
    sendA(1'b1, 64'hB, 12'h3B, 5'd2);
    cycA("fl B");
    flush = 1'b1;
    sendA(1'b1, 64'hC, 12'h3C, 5'd3);
    cycA("flush");
    chk("flush out_valid", 64'(dnA.valid), 64'd0);
    chk("flush in_ready",  64'(upA.ready), 64'd1);
    flush = 1'b0;
    sendA(1'b0, 64'd0, 12'd0, 5'd0);
    dnA.ready = 1'b1;
    cycA("after flush");

    // All-ones control lasts exactly one cycle, then a zeroed bubble.
    sendA(1'b1, 64'h77, 12'hFFF, 5'd7);
    cycA("bubble load");
    chk("bubble ctrl ones", 64'(dnA.ctrl), 64'hFFF);
    sendA(1'b0, 64'd0, 12'd0, 5'd0);
    cycA("bubble idle");
    chk("bubble ctrl zero", 64'(dnA.ctrl), 64'd0);
    chk("bubble data zero", dnA.data, 64'd0);

    // Reset while FULL, then latency-one recovery.
    dnA.ready = 1'b0;
    sendA(1'b1, 64'h1A, 12'h11, 5'd3);
    cycA("rst fill A");
    sendA(1'b1, 64'h1B, 12'h12, 5'd4);
    cycA("rst fill B");
    sendA(1'b0, 64'd0, 12'd0, 5'd0);
    dnA.ready = 1'b1;
    reset = 1'b1;
    cycA("mid reset");
    chk("mid reset count", 64'(countA), 64'd0);
    reset = 1'b0;
    sendA(1'b1, 64'h55, 12'h5, 5'd5);
    cycA("post reset");
    chk("post reset valid", 64'(dnA.valid), 64'd1);
    chk("post reset data",  dnA.data,       64'h55);
    sendA(1'b0, 64'd0, 12'd0, 5'd0);
    cycA("post reset drain");

    // Narrow instance under a random valid/ready stream.
    cycB(acc, pp);
    cycB(acc, pp);
    resetB = 1'b0;
    sent = 0;
    recv = 0;
    for (int c = 0; c < 20000 && recv < 1000; c++) begin
      upB.valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      upB.data  = $urandom;
      upB.ctrl  = 4'($urandom);
      upB.rd    = 5'($urandom);
      dnB.ready = ($urandom_range(0, 3) != 0);
      cycB(acc, pp);
      if (acc) sent++;
      if (pp)  recv++;
    end
    chk("sweep sent",     64'(sent), 64'd1000);
    chk("sweep received", 64'(recv), 64'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
# ex_mem_skid_reg

Parametrised elastic pipeline register that replaces the fixed EX→MEM stage register. It carries a control bundle and a data payload from execute to memory with a valid/ready handshake. A two-entry skid buffer lets upstream stall without a combinational ready path, and a single-cycle flush squashes everything in flight. Bubbles present all-zero control so downstream never sees a spurious write.

## Interface
Parameters:
- DATA_W, 64: payload width (ALU result, store data, branch target, concatenated).
- CTRL_W, 12: control bundle width (MemRead, MemWrite, memToReg, regWrite, branch, less, zero, funct[3:0], spare).
- RD_W, 5: destination register index width.
- ZERO_DATA_ON_BUBBLE, 1: 1 = data and rd also forced to 0 when the output is not valid; 0 = data/rd hold their last value.

Ports:
- clk, in, 1: single clock, all state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- flush, in, 1: synchronous squash of all held entries (branch mispredict).
- in_valid, in, 1: upstream entry present.
- in_ready, out, 1: stage can accept; registered, not a function of out_ready.
- in_ctrl, in, CTRL_W: control bundle.
- in_rd, in, RD_W: destination register.
- in_data, in, DATA_W: payload.
- out_valid, out, 1: head entry present.
- out_ready, in, 1: downstream accepts the head this cycle.
- out_ctrl, out, CTRL_W: head control; all zero whenever out_valid=0.
- out_rd, out, RD_W: head destination register.
- out_data, out, DATA_W: head payload.
- count, out, 2: entries held (0..2).

## Operation
- Storage: main slot (drives outputs) and skid slot, each with a valid bit.
- FSM, encoded by the valid bits:
  - EMPTY: both slots invalid.
  - ONE: main slot valid, skid slot invalid.
  - FULL: both slots valid.
- in_ready = 1 in EMPTY and ONE, 0 in FULL. It is derived from registered state only.
- Handshake: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY: accept → ONE, entry loads into main.
  - ONE: accept & pop → ONE, main reloads from input. Accept only → FULL, entry loads into skid. Pop only → EMPTY.
  - FULL: pop → ONE, main loads from skid. No pop → FULL, hold.
- Order: entries leave in arrival order.
- Flush: reset and flush act identically. The next state is EMPTY.
  - Any input presented in a flush cycle is dropped, even when in_valid=1.
  - A pop in a flush cycle still counts as consumed by downstream.
- Reset values:
  - out_valid=0, in_ready=1, count=0.
  - out_ctrl=0, out_rd=0, out_data=0.
  - Skid slot zeroed.
- Bubble rule: out_ctrl is registered as 0 whenever the next state leaves main invalid. Do not gate it combinationally after the register.
- Payload is never modified. No arithmetic is performed on it.

## Timing
- Latency: one cycle from accept to out_valid when the stage is EMPTY or popping.
- Throughput: one entry per cycle while out_ready=1.
- Stall recovery: when out_ready drops, one extra entry is absorbed by the skid slot. in_ready falls the following cycle.
- in_ready rises the cycle after the first pop out of FULL.
- Flush asserted in cycle N gives out_valid=0, out_ctrl=0 and in_ready=1 in cycle N+1.
- No combinational path from any input to any output.

## Structure
- Shared package pipe_pkg holds:
  - XLEN=64 and REG_ADDR_W=5.
  - The ex_mem_ctrl_t packed struct, with CTRL_W derived as its $bits.
  - State encoding constants ST_EMPTY, ST_ONE, ST_FULL.
- One sub-module, pipe_slot: a valid + ctrl + rd + data register with load, clear and zero-on-invalid behaviour. It is instantiated twice (main and skid).
- Top level holds the FSM and the mux selecting the main-slot source (input or skid).

## Test plan
- Reset then stream: reset 2 cycles, then send 4 entries (data 0x1..0x4) with out_ready=1 every cycle. Out sees 0x1..0x4 on consecutive cycles one cycle late; count stays ≤1 and in_ready stays 1.
- Backpressure: out_ready=0 while sending 0xA, 0xB, 0xC. 0xA sits on the output, 0xB fills skid and count=2. in_ready=0 the next cycle, so 0xC is held upstream. Raising out_ready then yields 0xA, 0xB, 0xC in order with no loss or duplication.
- Flush in FULL: with FULL holding 0xA/0xB, assert flush together with in_valid and 0xC. Next cycle out_valid=0, out_ctrl=0, count=0, in_ready=1, and 0xC never appears.
- Bubble control: in_ctrl=all ones (regWrite=1, MemWrite=1) followed by an idle cycle. out_ctrl equals all ones for exactly one cycle, then 0. With ZERO_DATA_ON_BUBBLE=1, out_data and out_rd also read 0.
- Reset mid-operation: in FULL, assert reset for 1 cycle with out_ready=1. The next cycle matches the reset values, and the first subsequent entry 0x55 appears with latency 1.
- Parameter sweep: DATA_W=32, CTRL_W=4 with a random valid/ready stream of 1000 entries. A scoreboard confirms in-order, lossless delivery, and out_ctrl=0 whenever out_valid=0.
